risc_fetch_unit: RTL and testbench

RISC_FETCH_UNIT -- requirements
Module: risc_fetch_unit

---
 rtl/risc_toy_pkg.sv | 19 +
 rtl/risc_sync_fifo.sv | 54 +++++
 rtl/risc_fetch_unit.sv | 82 ++++++++
 tb/tb_risc_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/risc_toy_pkg.sv
// Shared constants for the toy RISC core: default fetch geometry and opcodes.
package risc_toy_pkg;

   localparam int unsigned AW_DEF          = 30;
   localparam int unsigned DW_DEF          = 32;
   localparam int unsigned RESET_PC_DEF    = 0;
   localparam int unsigned FETCH_DEPTH_DEF = 4;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

endpackage

// File: rtl/risc_sync_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module risc_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   FLUSH,
   input  logic                   PUSH,
   input  logic                   POP,
   input  logic [WIDTH-1:0]       WDATA,
   output logic [WIDTH-1:0]       RDATA,
   output logic [$clog2(DEPTH):0] COUNT
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   // Pop only when non-empty; push into a full FIFO only if a pop frees a slot.
   assign do_pop  = POP & (count_q != '0);
   assign do_push = PUSH & ((count_q != CW'(DEPTH)) | do_pop);

   // Storage array, deliberately not reset.
   always_ff @(posedge CLK) begin
      if (do_push & !RST & !FLUSH) begin
         mem_q[wr_ptr_q] <= WDATA;
      end
   end

   // Pointers and occupancy; reset and flush clear them.
   always_ff @(posedge CLK) begin
      if (RST | FLUSH) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign RDATA = mem_q[rd_ptr_q];
   assign COUNT = count_q;

endmodule

// File: rtl/risc_fetch_unit.sv
// Instruction fetch unit: credit-based prefetch into a small {instr, pc} buffer
// with redirect support.
module risc_fetch_unit
   import risc_toy_pkg::*;
#(
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned DEPTH    = FETCH_DEPTH_DEF,
   parameter int unsigned RESET_PC = RESET_PC_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   output logic          IREQ,
   output logic [AW-1:0] IADDR,
   input  logic [DW-1:0] INSTR,
   input  logic          REDIR,
   input  logic [AW-1:0] REDIR_PC,
   output logic          F_VALID,
   output logic [DW-1:0] F_INSTR,
   output logic [AW-1:0] F_PC,
   input  logic          F_READY
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned FW = DW + AW;

   logic [AW-1:0] pc_q;
   logic [AW-1:0] req_pc_q;
   logic          inflight_q;
   logic [CW-1:0] count;
   logic [FW-1:0] head;
   logic          credit_ok;
   logic          valid;
   logic          push;
   logic          pop;

   // A request is allowed only if its return is guaranteed a buffer slot.
   assign credit_ok = (count + CW'(inflight_q)) < CW'(DEPTH);
   assign IREQ      = !RST & !REDIR & credit_ok;
   assign IADDR     = pc_q;

   // Head visibility; a redirect squashes both the return and any pop.
   assign valid = !RST & (count != '0);
   assign pop   = valid & F_READY & !REDIR;
   assign push  = inflight_q & !REDIR;

   // Fetch PC, in-flight flag and the address of the outstanding request.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q       <= AW'(RESET_PC);
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= IREQ;
         if (IREQ) req_pc_q <= pc_q;
         if (REDIR) begin
            pc_q <= REDIR_PC;
         end else if (IREQ) begin
            pc_q <= pc_q + AW'(1);
         end
      end
   end

   risc_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_buf (
      .CLK   (CLK),
      .RST   (RST),
      .FLUSH (REDIR),
      .PUSH  (push),
      .POP   (pop),
      .WDATA ({INSTR, req_pc_q}),
      .RDATA (head),
      .COUNT (count)
   );

   assign F_VALID = valid;
   assign F_INSTR = valid ? head[FW-1:AW] : '0;
   assign F_PC    = valid ? head[AW-1:0]  : '0;

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Directed bench for risc_fetch_unit: a main instance (DEPTH 4), a DEPTH 2
// instance for throughput and an AW 4 instance for PC wrap.
module tb_risc_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;

   // main instance
   logic        IREQ, REDIR, F_VALID, F_READY;
   logic [29:0] IADDR, REDIR_PC, F_PC;
   logic [31:0] INSTR, F_INSTR;

   // DEPTH 2 instance
   logic        ireq2, fv2;
   logic [29:0] iaddr2, fpc2;
   logic [31:0] instr2, finstr2;

   // AW 4 instance
   logic        ireq_w, fv_w;
   logic [3:0]  iaddr_w, fpc_w;
   logic [31:0] instr_w, finstr_w;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   risc_fetch_unit dut (
      .CLK(CLK), .RST(RST), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
      .REDIR(REDIR), .REDIR_PC(REDIR_PC), .F_VALID(F_VALID),
      .F_INSTR(F_INSTR), .F_PC(F_PC), .F_READY(F_READY)
   );

   risc_fetch_unit #(.DEPTH(2)) dut2 (
      .CLK(CLK), .RST(RST), .IREQ(ireq2), .IADDR(iaddr2), .INSTR(instr2),
      .REDIR(1'b0), .REDIR_PC(30'h0), .F_VALID(fv2),
      .F_INSTR(finstr2), .F_PC(fpc2), .F_READY(1'b1)
   );

   risc_fetch_unit #(.AW(4), .RESET_PC(15)) dut_w (
      .CLK(CLK), .RST(RST), .IREQ(ireq_w), .IADDR(iaddr_w), .INSTR(instr_w),
      .REDIR(1'b0), .REDIR_PC(4'h0), .F_VALID(fv_w),
      .F_INSTR(finstr_w), .F_PC(fpc_w), .F_READY(1'b1)
   );

   function automatic logic [31:0] memf(input logic [29:0] a);
      return 32'hC0DE_0000 ^ {2'b00, a};
   endfunction

   // Instruction memory: data for the address presented now appears next cycle.
   always @(posedge CLK) begin
      INSTR   <= memf(IADDR);
      instr2  <= memf(iaddr2);
      instr_w <= memf(30'(iaddr_w));
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      REDIR = 1'b0;
      #2;
      chk("rst_ireq", 64'(IREQ), 64'd0);
      chk("rst_fvalid", 64'(F_VALID), 64'd0);
      chk("rst_finstr", 64'(F_INSTR), 64'd0);
      chk("rst_fpc", 64'(F_PC), 64'd0);
      tick();
      RST = 1'b0;
   endtask

   typedef struct {
      logic        redir;
      logic [29:0] rpc;
      logic        rdy;
      logic        ireq;
      logic [29:0] iaddr;
      logic        fv;
      logic [29:0] fpc;
   } vec_t;

   localparam int NV = 15;
   vec_t vec [NV];

   initial begin
      int nreq;
      int got;
      int n2;
      logic [29:0] e;
      logic [29:0] e2;

      // cycles 1..15 after reset release
      vec[0]  = '{1'b0, 30'h0,  1'b1, 1'b1, 30'h0,  1'b0, 30'h0};
      vec[1]  = '{1'b0, 30'h0,  1'b1, 1'b1, 30'h1,  1'b0, 30'h0};
      vec[2]  = '{1'b0, 30'h0,  1'b1, 1'b1, 30'h2,  1'b1, 30'h0};
      vec[3]  = '{1'b0, 30'h0,  1'b1, 1'b1, 30'h3,  1'b1, 30'h1};
      vec[4]  = '{1'b0, 30'h0,  1'b1, 1'b1, 30'h4,  1'b1, 30'h2};
      vec[5]  = '{1'b0, 30'h0,  1'b1, 1'b1, 30'h5,  1'b1, 30'h3};
      vec[6]  = '{1'b1, 30'h40, 1'b1, 1'b0, 30'h6,  1'b1, 30'h4};
      vec[7]  = '{1'b0, 30'h0,  1'b0, 1'b1, 30'h40, 1'b0, 30'h0};
      vec[8]  = '{1'b0, 30'h0,  1'b0, 1'b1, 30'h41, 1'b0, 30'h0};
      vec[9]  = '{1'b0, 30'h0,  1'b1, 1'b1, 30'h42, 1'b1, 30'h40};
      vec[10] = '{1'b1, 30'h80, 1'b1, 1'b0, 30'h43, 1'b1, 30'h41};
      vec[11] = '{1'b1, 30'h90, 1'b1, 1'b0, 30'h80, 1'b0, 30'h0};
      vec[12] = '{1'b0, 30'h0,  1'b1, 1'b1, 30'h90, 1'b0, 30'h0};
      vec[13] = '{1'b0, 30'h0,  1'b1, 1'b1, 30'h91, 1'b0, 30'h0};
      vec[14] = '{1'b0, 30'h0,  1'b1, 1'b1, 30'h92, 1'b1, 30'h90};

      RST = 1'b1; REDIR = 1'b0; REDIR_PC = '0; F_READY = 1'b1;
      tick();

      // Table: streaming, redirect latency, back-to-back redirects.
      do_reset();
      for (int i = 0; i < NV; i++) begin
         REDIR = vec[i].redir; REDIR_PC = vec[i].rpc; F_READY = vec[i].rdy;
         #2;
         chk($sformatf("v%0d_ireq", i), 64'(IREQ), 64'(vec[i].ireq));
         chk($sformatf("v%0d_iaddr", i), 64'(IADDR), 64'(vec[i].iaddr));
         chk($sformatf("v%0d_fvalid", i), 64'(F_VALID), 64'(vec[i].fv));
         chk($sformatf("v%0d_fpc", i), 64'(F_PC), 64'(vec[i].fpc));
         chk($sformatf("v%0d_finstr", i), 64'(F_INSTR),
             64'(vec[i].fv ? memf(vec[i].fpc) : 32'h0));
         tick();
      end
      REDIR = 1'b0;

      // Backpressure: buffer fills to DEPTH then drains in order.
      do_reset();
      F_READY = 1'b0;
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         #2;
         if (IREQ) nreq++;
         tick();
      end
      chk("bp_nreq", 64'(nreq), 64'd4);
      #2;
      chk("bp_ireq_low", 64'(IREQ), 64'd0);
      chk("bp_head", 64'(F_PC), 64'd0);
      tick();
      F_READY = 1'b1;
      e = '0; got = 0;
      for (int i = 0; i < 40 && got < 8; i++) begin
         #2;
         if (F_VALID) begin
            chk("bp_drain_pc", 64'(F_PC), 64'(e));
            chk("bp_drain_instr", 64'(F_INSTR), 64'(memf(e)));
            e++; got++;
         end
         tick();
      end
      chk("bp_drain_count", 64'(got), 64'd8);

      // Redirect with count=3, inflight=1.
      do_reset();
      F_READY = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      REDIR = 1'b1; REDIR_PC = 30'h100;
      #2;
      chk("rd_ireq_in_redir", 64'(IREQ), 64'd0);
      tick();
      REDIR = 1'b0; F_READY = 1'b1;
      #2;
      chk("rd_ireq", 64'(IREQ), 64'd1);
      chk("rd_iaddr", 64'(IADDR), 64'h100);
      chk("rd_nostale1", 64'(F_VALID), 64'd0);
      tick(); #2;
      chk("rd_nostale2", 64'(F_VALID), 64'd0);
      tick(); #2;
      chk("rd_fv", 64'(F_VALID), 64'd1);
      chk("rd_fpc0", 64'(F_PC), 64'h100);
      chk("rd_finstr0", 64'(F_INSTR), 64'(memf(30'h100)));
      tick(); #2;
      chk("rd_fpc1", 64'(F_PC), 64'h101);
      tick(); #2;
      chk("rd_fpc2", 64'(F_PC), 64'h102);
      tick();

      // Reset with inflight=1, count=2; reset dominates a simultaneous redirect.
      do_reset();
      F_READY = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      RST = 1'b1; REDIR = 1'b1; REDIR_PC = 30'h200; F_READY = 1'b1;
      #2;
      chk("mr_ireq", 64'(IREQ), 64'd0);
      chk("mr_fvalid", 64'(F_VALID), 64'd0);
      tick();
      RST = 1'b0; REDIR = 1'b0;
      #2;
      chk("mr_fvalid_after", 64'(F_VALID), 64'd0);
      chk("mr_iaddr", 64'(IADDR), 64'd0);
      tick(); #2;
      chk("mr_fvalid_after2", 64'(F_VALID), 64'd0);
      tick(); #2;
      chk("mr_fvalid3", 64'(F_VALID), 64'd1);
      chk("mr_fpc", 64'(F_PC), 64'd0);
      chk("mr_finstr", 64'(F_INSTR), 64'(memf(30'd0)));
      tick();

      // PC wrap (AW=4) and DEPTH=2 throughput, 20 cycles from reset.
      do_reset();
      e2 = '0; n2 = 0;
      for (int c = 1; c <= 20; c++) begin
         #2;
         if (c == 1) chk("wr_iaddr15", 64'(iaddr_w), 64'd15);
         if (c == 2) chk("wr_iaddr0", 64'(iaddr_w), 64'd0);
         if (c == 3) chk("wr_fpc15", 64'(fpc_w), 64'd15);
         if (c == 4) begin
            chk("wr_fpc0", 64'(fpc_w), 64'd0);
            chk("wr_finstr0", 64'(finstr_w), 64'(memf(30'd0)));
         end
         if (fv2) begin
            chk("d2_pc", 64'(fpc2), 64'(e2));
            chk("d2_instr", 64'(finstr2), 64'(memf(e2)));
            e2++; n2++;
         end
         tick();
      end
      chk("d2_rate", 64'(n2 >= 9), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
